// File: rtl/fft_bist_pkg.sv
// fft_bist_pkg: shared definitions for the FFT stream BIST controller.
// FSM state encoding, packed complex field positions, default word width.
package fft_bist_pkg;

   localparam int DATA_W_DEF = 34;

   // {re_sign, re_int, re_frac, im_sign, im_int, im_frac}
   localparam int RE_SIGN = 33;
   localparam int IM_SIGN = 16;
   localparam int INT_W   = 8;
   localparam int FRAC_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/fft_stream_bist_if.sv
// fft_stream_bist_if: ROM address/data and DUT data bus of the FFT BIST.
// master = BIST controller side, slave = ROMs + datapath side.
interface fft_stream_bist_if import fft_bist_pkg::*; #(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FRAME_LEN = 16
);
   localparam int AW = $clog2(FRAME_LEN);

   logic [AW-1:0]     mem_addr;
   logic [DATA_W-1:0] stim_rdata;
   logic [DATA_W-1:0] exp_rdata;
   logic [DATA_W-1:0] dut_data_in;
   logic [DATA_W-1:0] dut_data_out;

   modport master (
      output mem_addr, dut_data_in,
      input  stim_rdata, exp_rdata, dut_data_out
   );

   modport slave (
      input  mem_addr, dut_data_in,
      output stim_rdata, exp_rdata, dut_data_out
   );
endinterface

// File: rtl/fft_bist_dly.sv
// fft_bist_dly: DEPTH-stage shift register for {valid, expected word}.
// DEPTH=0 degenerates to a wire. Reset flushes everything in flight.
module fft_bist_dly import fft_bist_pkg::*; #(
   parameter int W     = DATA_W_DEF + 1,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   generate
      if (DEPTH == 0) begin : g_wire
         assign q = d;
      end else begin : g_sr
         logic [DEPTH-1:0][W-1:0] sr;

         // shift toward the output end, one stage per cycle
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sr <= '0;
            end else begin
               sr[0] <= d;
               for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
         end

         assign q = sr[DEPTH-1];
      end
   endgenerate
endmodule

// File: rtl/fft_stream_bist.sv
// fft_stream_bist: streams stimulus ROM frames into the FFT datapath,
// aligns the expected ROM stream to the datapath latency and counts
// mismatches. Optional FFT_BIST_FIRSTERR_EN adds first-mismatch capture
// (first_err_idx / first_err_data).
module fft_stream_bist import fft_bist_pkg::*; #(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FRAME_LEN = 16,
   parameter int LAT       = 1,
   parameter int ERR_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        frames,
   fft_stream_bist_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt
`ifdef FFT_BIST_FIRSTERR_EN
   ,
   output logic [15:0]       first_err_idx,
   output logic [DATA_W-1:0] first_err_data
`endif
);
   localparam int AW = $clog2(FRAME_LEN);
   localparam int CW = AW + 8;   // run-wide sample counter
   localparam int DW = 5;        // drain counter, holds LAT+1 <= 16

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     s_last;
   logic [DW-1:0]     dcnt;
   logic [7:0]        frames_q;
   logic              zero_pend;
   logic              accept, issue, last_issue, drain_end;
   logic [1:0]        vld_pipe;  // [0] ROM data valid, [1] dut_data_in valid
   logic [DATA_W-1:0] din_q, exp_q, cmp_exp;
   logic              cmp_vld, mismatch;
   logic [ERR_W-1:0]  err_nxt;

   // done cycle blocks start so a held start is taken one cycle after done
   assign accept     = (state == ST_IDLE) && start && !done && !zero_pend;
   assign issue      = (state == ST_DRIVE);
   assign s_last     = {frames_q, {AW{1'b0}}} - {{(CW-1){1'b0}}, 1'b1};
   assign last_issue = (cnt == s_last);
   assign drain_end  = (dcnt == DW'(LAT + 1));
   assign busy       = (state != ST_IDLE);

   assign bus.mem_addr    = cnt[AW-1:0];
   assign bus.dut_data_in = din_q;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // next-state: IDLE -> DRIVE -> DRAIN -> IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept && frames != 8'd0) state_nxt = ST_DRIVE;
         ST_DRIVE: if (last_issue)               state_nxt = ST_DRAIN;
         ST_DRAIN: if (drain_end)                state_nxt = ST_IDLE;
         default:                                state_nxt = ST_IDLE;
      endcase
   end

   // sample/drain counters; low sample bits double as the ROM address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         dcnt      <= '0;
         frames_q  <= '0;
         zero_pend <= 1'b0;
      end else begin
         zero_pend <= accept && (frames == 8'd0);
         if (accept) begin
            frames_q <= frames;
            cnt      <= '0;
         end else if (issue) begin
            cnt <= last_issue ? '0 : cnt + CW'(1);
         end
         dcnt <= (state == ST_DRAIN) ? dcnt + DW'(1) : '0;
      end
   end

   // ROM read stage -> registered DUT drive; invalid slots drive zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         din_q    <= '0;
         exp_q    <= '0;
      end else begin
         vld_pipe <= {vld_pipe[0], issue};
         din_q    <= vld_pipe[0] ? bus.stim_rdata : '0;
         exp_q    <= vld_pipe[0] ? bus.exp_rdata  : '0;
      end
   end

   fft_bist_dly #(.W(DATA_W + 1), .DEPTH(LAT)) u_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({vld_pipe[1], exp_q}),
      .q     ({cmp_vld, cmp_exp})
   );

   assign mismatch = cmp_vld && (bus.dut_data_out != cmp_exp);

   always_comb begin
      err_nxt = err_cnt;
      if (accept)                         err_nxt = '0;
      else if (mismatch && err_cnt != '1) err_nxt = err_cnt + ERR_W'(1);
   end

   // run status: saturating error count, done pulse, sticky pass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
         done    <= 1'b0;
         pass    <= 1'b0;
      end else begin
         err_cnt <= err_nxt;
         done    <= ((state == ST_DRAIN) && drain_end) || zero_pend;
         if (accept)                             pass <= 1'b0;
         else if ((state == ST_DRAIN) && drain_end) pass <= (err_nxt == '0);
         else if (zero_pend)                     pass <= 1'b1;
      end
   end

`ifdef FFT_BIST_FIRSTERR_EN
   logic [15:0] cmp_idx;
   logic        err_seen;

   // capture index and observed word of the first mismatch in a run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_idx        <= '0;
         err_seen       <= 1'b0;
         first_err_idx  <= '0;
         first_err_data <= '0;
      end else if (accept) begin
         cmp_idx        <= '0;
         err_seen       <= 1'b0;
         first_err_idx  <= '0;
         first_err_data <= '0;
      end else if (cmp_vld) begin
         cmp_idx <= cmp_idx + 16'd1;
         if (mismatch && !err_seen) begin
            err_seen       <= 1'b1;
            first_err_idx  <= cmp_idx;
            first_err_data <= bus.dut_data_out;
         end
      end
   end
`endif

endmodule
